// File: rtl/mips_muldiv_unit.sv
// Multiply/divide unit owning HI/LO: iterative shift-add MULT/MULTU, restoring DIV/DIVU, plus MTHI/MTLO.
// Defining MDU_FAST_MUL_EN replaces the iterative multiply with one combinational multiplier; divide is unaffected.
module mips_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

`ifdef MDU_FAST_MUL_EN
    localparam state_t MUL_START = FIX;
`else
    localparam state_t MUL_START = CALC;
`endif

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, mag;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic               neg_q, neg_r, div_zero;

    logic               accept, is_signed, sign_a, sign_b, fix_write;
    logic [WIDTH-1:0]   abs_a, abs_b, quo_fix, rem_fix, hi_nxt, lo_nxt;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign op_ready  = (state == IDLE);
    assign busy      = ~op_ready;
    assign accept    = op_valid && op_ready && !flush;
    assign fix_write = (state == FIX) && !flush;

    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign sign_a    = is_signed & a[WIDTH-1];
    assign sign_b    = is_signed & b[WIDTH-1];
    assign abs_a     = sign_a ? -a : a;
    assign abs_b     = sign_b ? -b : b;

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        acc_nxt   = acc;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag} : '0);
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, mag};
        if (op_q[1]) begin
            if (!div_diff[WIDTH])
                acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_nxt = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        end
    end

`ifdef MDU_FAST_MUL_EN
    assign prod = {{WIDTH{1'b0}}, mag} * {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
`else
    assign prod = acc;
`endif

    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    // -2^(W-1) / -1 needs no special case: magnitude quotient is 2^(W-1) with positive sign
    always_comb begin
        hi_nxt = hi;
        lo_nxt = lo;
        case (op_q)
            OP_MULT, OP_MULTU: {hi_nxt, lo_nxt} = prod_fix;
            OP_DIV, OP_DIVU: begin
                if (div_zero) begin
                    lo_nxt = '1;
                    hi_nxt = a_q;
                end else begin
                    lo_nxt = quo_fix;
                    hi_nxt = rem_fix;
                end
            end
            OP_MTHI: hi_nxt = a_q;
            OP_MTLO: lo_nxt = a_q;
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT, OP_MULTU: state_nxt = MUL_START;
                        OP_DIV, OP_DIVU:   state_nxt = CALC;
                        OP_MTHI, OP_MTLO:  state_nxt = FIX;
                        default:           state_nxt = IDLE;
                    endcase
                end
            end
            CALC: begin
                if (flush)
                    state_nxt = IDLE;
                else if (cnt == CNT_W'(WIDTH-1))
                    state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            a_q      <= '0;
            mag      <= '0;
            acc      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            state <= state_nxt;
            done  <= fix_write;
            if (state == CALC && state_nxt == CALC)
                cnt <= cnt + CNT_W'(1);
            else
                cnt <= '0;
            if (accept) begin
                op_q     <= op;
                a_q      <= a;
                neg_q    <= sign_a ^ sign_b;
                neg_r    <= sign_a;
                div_zero <= (b == '0);
                if (op[1]) begin
                    acc <= {{WIDTH{1'b0}}, abs_a};
                    mag <= abs_b;
                end else begin
                    acc <= {{WIDTH{1'b0}}, abs_b};
                    mag <= abs_a;
                end
            end else if (state == CALC) begin
                acc <= acc_nxt;
            end
            if (fix_write) begin
                hi <= hi_nxt;
                lo <= lo_nxt;
            end
        end
    end
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Table-driven bench for mips_muldiv_unit with a result scoreboard checking HI/LO and issue-to-done latency.
module tb_mips_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [2:0]  op = 3'd7;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    mips_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op(op), .a(a), .b(b), .flush(flush), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi, lo;
        longint      t0;
        int          lat;
        string       tag;
    } exp_t;

    vec_t        vecs[16];
    exp_t        sb[$];
    exp_t        e;
    longint      edges;
    int          checks = 0;
    int          passes = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passes++;
    endtask

    function automatic int exp_lat(input logic [2:0] o);
        if (o >= 3'd4) return 1;
`ifdef MDU_FAST_MUL_EN
        if (o <= 3'd1) return 1;
`endif
        return 33;
    endfunction

    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] ehi, output logic [31:0] elo);
        logic [63:0] p;
        int sx, sy;
        ehi = mhi;
        elo = mlo;
        sx = x;
        sy = y;
        case (o)
            3'd0: begin p = longint'(sx) * longint'(sy); {ehi, elo} = p; end
            3'd1: begin p = {32'd0, x} * {32'd0, y}; {ehi, elo} = p; end
            3'd2: begin
                if (y == 0) begin elo = '1; ehi = x; end
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin elo = 32'h80000000; ehi = 0; end
                else begin elo = sx / sy; ehi = sx % sy; end
            end
            3'd3: begin
                if (y == 0) begin elo = '1; ehi = x; end
                else begin elo = x / y; ehi = x % y; end
            end
            3'd4: ehi = x;
            3'd5: elo = x;
            default: ;
        endcase
    endfunction

    // Holds op_valid until the unit is ready, then records the expected result at the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ehi, input logic [31:0] elo, input string tag);
        int n = 0;
        exp_t r;
        @(negedge clk);
        op_valid = 1'b1; op = o; a = x; b = y;
        while (!op_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) begin
            chk({tag, "_accept_timeout"}, 64'd0, 64'd1);
            op_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (o < 3'd6) begin
            r.hi = ehi; r.lo = elo; r.t0 = $time; r.lat = exp_lat(o); r.tag = tag;
            sb.push_back(r);
        end
        #1 op_valid = 1'b0;
        mhi = ehi;
        mlo = elo;
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                edges = ($time - 5 - e.t0) / 10;
                chk({e.tag, "_hi"}, hi, e.hi);
                chk({e.tag, "_lo"}, lo, e.lo);
                chk({e.tag, "_latency"}, edges, e.lat);
            end
        end
    end

    initial begin
        logic [31:0] ehi, elo;
        logic        seen;
        int          n;

        vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3]  = '{3'd0, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2};
        vecs[4]  = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[5]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[6]  = '{3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[7]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[8]  = '{3'd3, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vecs[9]  = '{3'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[10] = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[11] = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC};
        vecs[12] = '{3'd2, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2};
        vecs[13] = '{3'd4, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'hFFFFFFF2};
        vecs[14] = '{3'd5, 32'hCAFEF00D, 32'h00000000, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[15] = '{3'd6, 32'h11111111, 32'h22222222, 32'hDEADBEEF, 32'hCAFEF00D};

        #1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", op_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));
            if (vecs[i].op >= 3'd6) begin
                chk($sformatf("vec%0d_nop_ready", i), op_ready, 1);
                repeat (3) @(negedge clk);
                chk($sformatf("vec%0d_nop_hi", i), hi, vecs[i].hi);
                chk($sformatf("vec%0d_nop_lo", i), lo, vecs[i].lo);
            end
        end

        for (int i = 0; i < 8; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = $urandom >> $urandom_range(0, 28);
            model(3'(i % 4), x, y, ehi, elo);
            issue(3'(i % 4), x, y, ehi, elo, $sformatf("rnd%0d", i));
        end

        // flush in the middle of a divide
        issue(3'd4, 32'hAAAAAAAA, 0, 32'hAAAAAAAA, mlo, "set_hi");
        issue(3'd5, 32'hAAAAAAAA, 0, 32'hAAAAAAAA, 32'hAAAAAAAA, "set_lo");
        n = 0;
        while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        op_valid = 1'b1; op = 3'd2; a = 32'h00001000; b = 32'h00000003;
        @(posedge clk);
        #1 op_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk("busy_mid_div", busy, 1);
        flush = 1'b1;
        @(posedge clk);
        #1 chk("busy_after_flush", busy, 0);
        flush = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
        chk("no_done_after_flush", seen, 0);
        chk("flush_hi_kept", hi, 32'hAAAAAAAA);
        chk("flush_lo_kept", lo, 32'hAAAAAAAA);
        issue(3'd5, 32'h00001234, 0, 32'hAAAAAAAA, 32'h00001234, "mtlo_after_flush");
        repeat (3) @(negedge clk);

        // flush coinciding with the request in IDLE
        @(negedge clk);
        op_valid = 1'b1; op = 3'd5; a = 32'h0000FFFF; flush = 1'b1;
        @(posedge clk);
        #1 chk("idle_flush_not_accepted", busy, 0);
        op_valid = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_flush_lo_kept", lo, 32'h00001234);

        // flush during the FIX cycle of MTHI
        @(negedge clk);
        op_valid = 1'b1; op = 3'd4; a = 32'h12345678;
        @(posedge clk);
        #1 op_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1 chk("fix_flush_done", done, 0);
        chk("fix_flush_hi_kept", hi, 32'hAAAAAAAA);
        chk("fix_flush_busy", busy, 0);
        flush = 1'b0;

        // async reset in the middle of a multiply
        issue(3'd1, 32'h00000003, 32'h00000005, 32'h0, 32'hF, "mul_before_reset");
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_hi", hi, 0);
        chk("async_rst_lo", lo, 0);
        chk("async_rst_ready", op_ready, 1);
        chk("async_rst_busy", busy, 0);
        sb.delete();
        mhi = '0;
        mlo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'd1, 32'h00000003, 32'h00000005, 32'h0, 32'hF, "mul_after_reset");

        n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
